// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module : mem_access_unit_pkg
// Brief  : Shared pipeline definitions for the data memory access unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DMEM_WORDS_DEFAULT = 256;

  // A request is illegal when it is not word aligned or falls past the memory.
  function automatic logic addr_is_illegal(input logic [31:0] addr, input int words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(words));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Load/store unit with fixed-latency data memory handshake.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int DMEM_WORDS  = DMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  localparam logic [3:0] c_cnt_load = 4'(MEM_LATENCY - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_write;
  logic       w_err;

  assign w_err     = addr_is_illegal(req_addr, DMEM_WORDS);
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      r_write        <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_err       <= 1'b0;
      mem_addr       <= 32'd0;
      mem_write_data <= 32'd0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            if (w_err) begin
              // Rejected requests never touch memory.
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              r_state        <= ACCESS;
              r_cnt          <= c_cnt_load;
              mem_addr       <= {2'b00, req_addr[31:2]};
              mem_write_data <= req_write ? req_wdata : 32'd0;
              mem_memread    <= !req_write;
              mem_memwrite   <= req_write;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state        <= RESP;
            resp_valid     <= 1'b1;
            resp_err       <= 1'b0;
            resp_rdata     <= r_write ? 32'd0 : mem_read_data;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state    <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Randomised and directed checks of mem_access_unit at latency 1 and 3.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_write_data [2];
  logic        mem_memwrite [2];
  logic        mem_memread [2];
  logic [31:0] mem_read_data [2];
  logic        busy [2];

  logic [31:0] dmem [2][256];
  logic [31:0] init_mem [2][256];
  logic [31:0] ref_mem [2][256];
  logic        mem_load;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]),
    .mem_memwrite(mem_memwrite[0]), .mem_memread(mem_memread[0]),
    .mem_read_data(mem_read_data[0]), .busy(busy[0])
  );

  mem_access_unit #(.MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]),
    .mem_memwrite(mem_memwrite[1]), .mem_memread(mem_memread[1]),
    .mem_read_data(mem_read_data[1]), .busy(busy[1])
  );

  assign mem_read_data[0] = dmem[0][mem_addr[0][7:0]];
  assign mem_read_data[1] = dmem[1][mem_addr[1][7:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_load) begin
        for (int i = 0; i < 256; i++) dmem[k][i] <= init_mem[k][i];
      end else if (mem_memwrite[k]) begin
        dmem[k][mem_addr[k][7:0]] <= mem_write_data[k];
      end
    end
  end

  always @(posedge clk) begin
    assert (!(mem_memread[0] && mem_memwrite[0])) else $error("FAIL strobe_excl dut0");
    assert (!(mem_memread[1] && mem_memwrite[1])) else $error("FAIL strobe_excl dut1");
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request/response; expectations come from the address rules
  // and the reference memory, not from watching the DUT.
  task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    logic        err;
    logic [31:0] exp_rd;
    int          lat, nrd, nwr, exp_lat, exp_strobes;
    err         = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    exp_rd      = (err || w) ? 32'd0 : ref_mem[k][a[9:2]];
    if (!err && w) ref_mem[k][a[9:2]] = d;
    exp_lat     = err ? 1 : lat_of(k) + 1;
    exp_strobes = err ? 0 : lat_of(k);

    chk("idle_req_ready", req_ready[k], 1);
    chk("idle_busy", busy[k], 0);
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    tick();
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;

    lat = 1; nrd = 0; nwr = 0;
    while (!resp_valid[k] && lat < 40) begin
      chk("wait_busy", busy[k], 1);
      chk("wait_req_ready", req_ready[k], 0);
      chk("strobe_excl", mem_memread[k] & mem_memwrite[k], 0);
      if (mem_memread[k]) nrd++;
      if (mem_memwrite[k]) nwr++;
      if (mem_memread[k] || mem_memwrite[k]) begin
        chk("mem_addr", mem_addr[k], {2'b00, a[31:2]});
        if (w) chk("mem_write_data", mem_write_data[k], d);
      end
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("read_strobes", nrd, (!w) ? exp_strobes : 0);
    chk("write_strobes", nwr, w ? exp_strobes : 0);
    chk("resp_err", resp_err[k], err);
    chk("resp_rdata", resp_rdata[k], exp_rd);
    chk("resp_strobes_low", mem_memread[k] | mem_memwrite[k], 0);

    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", resp_valid[k], 1);
      chk("hold_rdata", resp_rdata[k], exp_rd);
      chk("hold_err", resp_err[k], err);
      chk("hold_req_ready", req_ready[k], 0);
      chk("hold_busy", busy[k], 1);
    end
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
    chk("after_valid", resp_valid[k], 0);
    chk("after_req_ready", req_ready[k], 1);
    chk("after_busy", busy[k], 0);
  endtask

  initial begin
    int k, kind;
    logic [31:0] a;
    for (int j = 0; j < 2; j++) begin
      req_valid[j] = 1'b0; req_write[j] = 1'b0; req_addr[j] = 32'd0;
      req_wdata[j] = 32'd0; resp_ready[j] = 1'b0;
      for (int i = 0; i < 256; i++) init_mem[j][i] = $urandom;
    end
    init_mem[0][3] = 32'hA5A5_0003;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 256; i++) ref_mem[j][i] = init_mem[j][i];

    rst = 1'b1;
    mem_load = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mem_load = 1'b0;
    tick();
    for (int j = 0; j < 2; j++) begin
      chk("rst_req_ready", req_ready[j], 1);
      chk("rst_busy", busy[j], 0);
      chk("rst_resp_valid", resp_valid[j], 0);
      chk("rst_resp_rdata", resp_rdata[j], 0);
      chk("rst_resp_err", resp_err[j], 0);
      chk("rst_mem_addr", mem_addr[j], 0);
      chk("rst_strobes", {31'd0, mem_memread[j] | mem_memwrite[j]}, 0);
    end

    // Directed scenarios at latency 1.
    do_txn(0, 1'b0, 32'h0000_000C, 32'd0, 0);
    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'd0, 1);
    do_txn(0, 1'b0, 32'h0000_0006, 32'd0, 0);
    do_txn(0, 1'b0, 32'h0000_0400, 32'd0, 0);

    // Backpressure at latency 3.
    do_txn(1, 1'b0, 32'h0000_0020, 32'd0, 5);

    // Reset during the second access cycle.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0000_0040;
    tick();
    req_valid[1] = 1'b0;
    chk("mid_first_read", mem_memread[1], 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_strobes", mem_memread[1] | mem_memwrite[1], 0);
    chk("mid_req_ready", req_ready[1], 1);
    chk("mid_busy", busy[1], 0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_resp", resp_valid[1], 0);
      tick();
    end

    // Random traffic on both units.
    for (int n = 0; n < 80; n++) begin
      k    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind == 0)
        a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (kind == 1)
        a = 32'($urandom_range(256, 5000)) << 2;
      else
        a = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      do_txn(k, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
